dac_burst_player: RTL and testbench
===================================

DAC_BURST_PLAYER -- requirements
Module: dac_burst_player

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 128, meaning the width of one parallel DAC word (tx_pkg::DATA_WIDTH) and of one DMA beat.
REQ-002 The module SHALL have parameter DEPTH, default 1024, meaning the number of DATA_WIDTH words stored in the waveform buffer; it SHALL be a power of 2.
REQ-003 The module SHALL have parameter AW, default $clog2(DEPTH), meaning the buffer address width.
REQ-004 The module SHALL have port clk, input, 1, the single DAC-domain clock; the block has one clock.
REQ-005 The module SHALL have port reset, input, 1, the asynchronous active-high reset.
REQ-006 The module SHALL have ports dma_in.data (input, DATA_WIDTH), dma_in.valid (input, 1), dma_in.last (input, 1) and dma_in.ready (output, 1), forming the Axis_If.Slave waveform load stream.
REQ-007 The module SHALL have ports start.data (input, 16), start.valid (input, 1) and start.ready (output, 1), forming the Axis_If.Slave start command; data is the burst repeat count.
REQ-008 The module SHALL have ports stop (input, 1), a single-cycle playback abort, and sw_reset (input, 1), a single-cycle synchronous clear.
REQ-009 The module SHALL have ports dac_out.data (output, DATA_WIDTH) and dac_out.valid (output, 1), forming the Realtime_If.Master sample stream.
REQ-010 The module SHALL have port burst_trigger, output, 1, pulsed with the first sample of each burst.
REQ-011 The module SHALL have status outputs write_depth (AW+1 bits, loaded word count), busy (1 bit, playing) and loaded (1 bit, buffer valid).

Function
REQ-012 The FSM SHALL have the states IDLE, LOADING, READY and PLAYING.
REQ-013 In IDLE and LOADING, dma_in.ready SHALL be 1 while the write address is below DEPTH; in READY and PLAYING it SHALL be 0.
REQ-014 Each dma_in beat with valid and ready both high SHALL be written at the write address, which then increments; the first such beat SHALL move the FSM from IDLE to LOADING.
REQ-015 An accepted beat with last=1, or the accepted beat at address DEPTH-1, SHALL move the FSM to READY, latch write_depth to the accepted count (1..DEPTH) and set loaded=1.
REQ-016 An empty buffer is not representable: write_depth=0 SHALL imply loaded=0.
REQ-017 start.ready SHALL equal 1 only in READY; a start.valid received in any other state SHALL be ignored and not queued.
REQ-018 A start handshake at cycle T SHALL latch the repeat count N, clear the read address and enter PLAYING at T+1.
REQ-019 N=0 SHALL mean repeat until stop.
REQ-020 The buffer read latency SHALL be 1 registered cycle, so the first dac_out.valid=1 occurs at T+2.
REQ-021 In PLAYING, dac_out.valid SHALL be 1 on every cycle, with consecutive addresses 0..write_depth-1, then wrap to 0 for the next burst with no gap cycle.
REQ-022 burst_trigger SHALL be 1 for exactly one cycle, coincident with dac_out carrying address 0 of each burst.
REQ-023 A 16-bit burst counter SHALL count completed bursts; when it equals N (N≠0) on the last address, the FSM SHALL return to READY and dac_out.valid SHALL drop the cycle after that last sample.
REQ-024 stop in PLAYING SHALL return the FSM to READY next cycle; at most 1 further sample (the one already in the read pipeline) SHALL appear, and it SHALL carry no trigger.
REQ-025 When stop coincides with the final sample of the final burst, the result SHALL be identical to REQ-023.
REQ-026 stop outside PLAYING SHALL have no effect.
REQ-027 With write_depth=1, the output SHALL repeat address 0, with burst_trigger high on every valid cycle.
REQ-028 busy SHALL be 1 exactly while the FSM is in PLAYING.
REQ-029 When dac_out.valid=0, dac_out.data SHALL be held at 0.
REQ-030 Buffer contents SHALL be preserved across playbacks; the buffer is reloaded only from IDLE.

Reset
REQ-031 On reset (asynchronous) or sw_reset (next clock), the FSM SHALL go to IDLE and all of the following SHALL clear to 0: write_depth, loaded, busy, dac_out.valid, dac_out.data, burst_trigger, both addresses and the burst counter.
REQ-032 Buffer RAM contents need not be cleared by reset or sw_reset.
REQ-033 sw_reset SHALL take priority over a simultaneous start, stop or dma beat; that beat SHALL be discarded.
REQ-034 A reset asserted mid-load or mid-playback SHALL abort the operation, and the first valid output after the abort SHALL require a new load and start.

Verification
REQ-035 The bench SHALL load 5 beats (last on beat 5) and start with N=2, and SHALL check: 10 valid samples ordered 0..4,0..4; burst_trigger on output cycles 1 and 6; first valid at T+2; valid low on cycle 11; write_depth=5.
REQ-036 The bench SHALL load DEPTH beats with no last, and SHALL check: READY after beat DEPTH, ready=0 afterwards, and write_depth=DEPTH.
REQ-037 The bench SHALL start with N=0 and assert stop after 37 output samples, and SHALL check: at most 38 samples in total, busy=0 next cycle, and a second start replays from address 0.
REQ-038 The bench SHALL drive start during LOADING and then last, and SHALL check that no output is produced until a new start arrives in READY.
REQ-039 The bench SHALL assert sw_reset and start in the same cycle, and SHALL check: IDLE, loaded=0, no output, and dma_in.ready=1.
REQ-040 The bench SHALL load 1 beat and start with N=3, and SHALL check: 3 valid samples, all equal to beat 0, with burst_trigger high on each.

Source files
------------

// File: rtl/dac_burst_player.sv
// Waveform burst player: captures a buffer of DAC words from a DMA stream, then replays
// it as gap-free bursts on a realtime sample stream with a per-burst trigger pulse.
module dac_burst_player #(
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 1024,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   // waveform load stream
   input  logic [DATA_WIDTH-1:0] dma_in_data,
   input  logic                  dma_in_valid,
   input  logic                  dma_in_last,
   output logic                  dma_in_ready,
   // start command, data is the burst repeat count (0 = until stop)
   input  logic [15:0]           start_data,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic                  stop,
   input  logic                  sw_reset,
   // realtime sample stream
   output logic [DATA_WIDTH-1:0] dac_out_data,
   output logic                  dac_out_valid,
   output logic                  burst_trigger,
   // status
   output logic [AW:0]           write_depth,
   output logic                  busy,
   output logic                  loaded
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOADING,
      S_READY,
      S_PLAYING
   } state_t;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   state_t r_state;
   state_t w_state_nxt;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic [AW:0]           r_wr_addr;
   logic [AW-1:0]         r_rd_addr;
   logic [15:0]           r_repeat;
   logic [15:0]           r_burst_cnt;
   logic [AW:0]           r_write_depth;
   logic                  r_loaded;
   logic                  r_out_valid;
   logic                  r_trigger;

   logic                  w_beat;
   logic                  w_start;
   logic                  w_issue;
   logic                  w_load_done;
   logic                  w_last_addr;
   logic                  w_play_done;
   logic [15:0]           w_cnt_inc;

   assign dma_in_ready = ((r_state == S_IDLE) || (r_state == S_LOADING)) && (r_wr_addr < DEPTH_W);
   assign start_ready  = (r_state == S_READY);

   // sw_reset wins over any handshake that lands in the same cycle
   assign w_beat      = dma_in_valid && dma_in_ready && !sw_reset;
   assign w_start     = start_valid && start_ready && !sw_reset;
   assign w_issue     = (r_state == S_PLAYING);
   assign w_load_done = w_beat && (dma_in_last || (r_wr_addr == DEPTH_W - 1'b1));
   assign w_last_addr = ({1'b0, r_rd_addr} == (r_write_depth - 1'b1));
   assign w_cnt_inc   = r_burst_cnt + 16'd1;
   assign w_play_done = w_issue && w_last_addr && (r_repeat != 16'd0) && (w_cnt_inc == r_repeat);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can infer a latch.
      w_state_nxt = r_state;
      if (sw_reset) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_LOADING: begin
               if (w_load_done) begin
                  w_state_nxt = S_READY;
               end else if (w_beat) begin
                  w_state_nxt = S_LOADING;
               end
            end
            S_READY: begin
               if (w_start) begin
                  w_state_nxt = S_PLAYING;
               end
            end
            S_PLAYING: begin
               if (stop || w_play_done) begin
                  w_state_nxt = S_READY;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_addr     <= '0;
         r_rd_addr     <= '0;
         r_repeat      <= '0;
         r_burst_cnt   <= '0;
         r_write_depth <= '0;
         r_loaded      <= 1'b0;
         r_out_valid   <= 1'b0;
         r_trigger     <= 1'b0;
      end else if (sw_reset) begin
         r_wr_addr     <= '0;
         r_rd_addr     <= '0;
         r_repeat      <= '0;
         r_burst_cnt   <= '0;
         r_write_depth <= '0;
         r_loaded      <= 1'b0;
         r_out_valid   <= 1'b0;
         r_trigger     <= 1'b0;
      end else begin
         if (w_beat) begin
            r_wr_addr <= r_wr_addr + 1'b1;
         end
         if (w_load_done) begin
            r_write_depth <= r_wr_addr + 1'b1;
            r_loaded      <= 1'b1;
         end
         if (w_start) begin
            r_repeat    <= start_data;
            r_rd_addr   <= '0;
            r_burst_cnt <= '0;
         end else if (w_issue) begin
            if (w_last_addr) begin
               r_rd_addr   <= '0;
               r_burst_cnt <= w_cnt_inc;
            end else begin
               r_rd_addr <= r_rd_addr + 1'b1;
            end
         end
         // the sample still in flight after a stop must not look like a new burst
         r_out_valid <= w_issue;
         r_trigger   <= w_issue && (r_rd_addr == '0) && !stop;
      end
   end

   // NOTE: the buffer RAM has no reset so it maps onto block RAM; validity is tracked by r_loaded.
   always_ff @(posedge clk) begin
      if (w_beat) begin
         r_mem[r_wr_addr[AW-1:0]] <= dma_in_data;
      end
      r_rd_data <= r_mem[r_rd_addr];
   end

   assign dac_out_data  = r_out_valid ? r_rd_data : '0;
   assign dac_out_valid = r_out_valid;
   assign burst_trigger = r_trigger;
   assign write_depth   = r_write_depth;
   assign busy          = (r_state == S_PLAYING);
   assign loaded        = r_loaded;

endmodule

// File: tb/tb_dac_burst_player.sv
// Directed bench for dac_burst_player with random waveform contents; expected samples come
// from a queue holding the loaded words, replayed as n bursts of write_depth words.
module tb_dac_burst_player;

   localparam int DW    = 128;
   localparam int DEPTH = 32;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] dma_in_data;
   logic          dma_in_valid;
   logic          dma_in_last;
   logic          dma_in_ready;
   logic [15:0]   start_data;
   logic          start_valid;
   logic          start_ready;
   logic          stop;
   logic          sw_reset;
   logic [DW-1:0] dac_out_data;
   logic          dac_out_valid;
   logic          burst_trigger;
   logic [AW:0]   write_depth;
   logic          busy;
   logic          loaded;

   always #5 clk = ~clk;

   dac_burst_player #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .dma_in_data  (dma_in_data),
      .dma_in_valid (dma_in_valid),
      .dma_in_last  (dma_in_last),
      .dma_in_ready (dma_in_ready),
      .start_data   (start_data),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .stop         (stop),
      .sw_reset     (sw_reset),
      .dac_out_data (dac_out_data),
      .dac_out_valid(dac_out_valid),
      .burst_trigger(burst_trigger),
      .write_depth  (write_depth),
      .busy         (busy),
      .loaded       (loaded)
   );

   int            vectors     = 0;
   int            miscompares = 0;
   logic [DW-1:0] ref_mem [$];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // inputs change and outputs are sampled at the falling edge, away from the active edge
   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic do_sw_reset();
      sw_reset = 1'b1;
      step();
      sw_reset = 1'b0;
      ref_mem.delete();
      chk("swrst_loaded", loaded, 0);
      chk("swrst_depth", write_depth, 0);
      chk("swrst_dma_ready", dma_in_ready, 1);
   endtask

   // n beats; optional last on the final beat; optional start_valid held during all but the final beat
   task automatic load(input int n, input bit use_last, input bit start_during);
      for (int i = 0; i < n; i++) begin
         logic [DW-1:0] w;
         w = rand_word();
         chk("load_dma_ready", dma_in_ready, 1);
         chk("load_start_ready", start_ready, 0);
         dma_in_valid = 1'b1;
         dma_in_data  = w;
         dma_in_last  = use_last && (i == n-1);
         start_valid  = start_during && (i != n-1);
         start_data   = 16'd1;
         ref_mem.push_back(w);
         step();
      end
      dma_in_valid = 1'b0;
      dma_in_last  = 1'b0;
      dma_in_data  = '0;
      start_valid  = 1'b0;
      chk("load_loaded", loaded, 1);
      chk("load_depth", write_depth, n);
      chk("load_in_ready_state", start_ready, 1);
      chk("load_dma_ready_after", dma_in_ready, 0);
   endtask

   // start n bursts; stop_after>0 asserts stop once that many samples were seen;
   // stop_final pulses stop around the final sample, which must not change anything
   task automatic play(input int n, input int stop_after, input bit stop_final);
      int depth, total, seen, limit;
      depth = ref_mem.size();
      total = n * depth;
      seen  = 0;
      limit = (n != 0) ? total + 2 : stop_after + 6;
      chk("play_start_ready", start_ready, 1);
      start_valid = 1'b1;
      start_data  = 16'(n);
      step();
      start_valid = 1'b0;
      chk("play_busy_t1", busy, 1);
      chk("play_valid_t1", dac_out_valid, 0);
      for (int c = 0; c < limit; c++) begin
         step();
         stop = 1'b0;
         if (stop_after != 0) begin
            if (dac_out_valid) begin
               chk("stop_data", dac_out_data, ref_mem[seen % depth]);
               chk("stop_trig", burst_trigger, (seen < stop_after) && (seen % depth == 0));
               seen++;
            end else begin
               chk("stop_idle_data", dac_out_data, 0);
            end
            if (c == stop_after) chk("stop_busy_next", busy, 0);
            if (seen == stop_after && c == stop_after - 1) stop = 1'b1;
         end else begin
            chk("play_valid", dac_out_valid, c < total);
            if (c < total) begin
               chk("play_data", dac_out_data, ref_mem[c % depth]);
               chk("play_trig", burst_trigger, (c % depth) == 0);
            end else begin
               chk("play_idle_data", dac_out_data, 0);
               chk("play_idle_trig", burst_trigger, 0);
               chk("play_idle_busy", busy, 0);
            end
            if (stop_final && (c == total - 2 || c == total - 1)) stop = 1'b1;
         end
      end
      stop = 1'b0;
      if (stop_after != 0) begin
         chk("stop_total_le", seen <= stop_after + 1, 1);
         chk("stop_total_ge", seen >= stop_after, 1);
         chk("stop_busy_end", busy, 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      dma_in_data  = '0;
      dma_in_valid = 1'b0;
      dma_in_last  = 1'b0;
      start_data   = '0;
      start_valid  = 1'b0;
      stop         = 1'b0;
      sw_reset     = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();

      chk("rst_depth", write_depth, 0);
      chk("rst_loaded", loaded, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", dac_out_valid, 0);
      chk("rst_data", dac_out_data, 0);
      chk("rst_trig", burst_trigger, 0);
      chk("rst_dma_ready", dma_in_ready, 1);
      chk("rst_start_ready", start_ready, 0);

      // stop while idle is ignored
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("idle_stop_dma_ready", dma_in_ready, 1);
      chk("idle_stop_depth", write_depth, 0);

      // 5-beat buffer, two bursts
      load(5, 1'b1, 1'b0);
      play(2, 0, 1'b0);
      // free-running playback aborted by stop, then replay from address 0
      play(0, 37, 1'b0);
      play(2, 0, 1'b0);
      // stop coincident with the final sample
      play(1, 0, 1'b1);

      // start offered during loading is dropped
      do_sw_reset();
      load(3, 1'b1, 1'b1);
      repeat (8) begin
         step();
         chk("no_queued_start_valid", dac_out_valid, 0);
         chk("no_queued_start_busy", busy, 0);
      end
      play(1, 0, 1'b0);

      // sw_reset and start together
      chk("swrst_start_pre", start_ready, 1);
      sw_reset    = 1'b1;
      start_valid = 1'b1;
      start_data  = 16'd4;
      step();
      sw_reset    = 1'b0;
      start_valid = 1'b0;
      ref_mem.delete();
      repeat (6) begin
         chk("swrst_start_valid", dac_out_valid, 0);
         chk("swrst_start_loaded", loaded, 0);
         chk("swrst_start_dma_ready", dma_in_ready, 1);
         chk("swrst_start_idle", start_ready, 0);
         chk("swrst_start_busy", busy, 0);
         chk("swrst_start_depth", write_depth, 0);
         step();
      end

      // full buffer with no last
      load(DEPTH, 1'b0, 1'b0);
      dma_in_valid = 1'b1;
      dma_in_data  = rand_word();
      step();
      dma_in_valid = 1'b0;
      chk("full_extra_ready", dma_in_ready, 0);
      chk("full_extra_depth", write_depth, DEPTH);
      play(1, 0, 1'b0);

      // single-word buffer
      do_sw_reset();
      load(1, 1'b1, 1'b0);
      play(3, 0, 1'b0);

      // asynchronous reset during playback
      chk("abort_start_ready", start_ready, 1);
      start_valid = 1'b1;
      start_data  = 16'd0;
      step();
      start_valid = 1'b0;
      repeat (4) step();
      chk("pre_abort_valid", dac_out_valid, 1);
      #1 reset = 1'b1;
      #1;
      chk("abort_valid", dac_out_valid, 0);
      chk("abort_data", dac_out_data, 0);
      chk("abort_busy", busy, 0);
      chk("abort_loaded", loaded, 0);
      chk("abort_depth", write_depth, 0);
      step();
      reset = 1'b0;
      ref_mem.delete();
      start_valid = 1'b1;
      start_data  = 16'd1;
      repeat (6) begin
         step();
         chk("abort_no_out", dac_out_valid, 0);
      end
      start_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
